// File: rtl/instr_feeder_pkg.sv
// Shared definitions for the instruction feeder and the processor it drives:
// FSM state encoding, opcode field values, the default halt word and the
// watchdog counter width.
package instr_feeder_pkg;

  localparam int unsigned INSTR_W       = 16;
  localparam int unsigned WDOG_W        = 8;
  localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    FETCH_IMM,
    ISSUE_IMM,
    EXEC,
    HALT,
    FAULT
  } state_e;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_MVNZ = 3'b110,
    OP_SLR  = 3'b111
  } opcode_e;

  // Opcode lives in bits [8:6] of the instruction word.
  function automatic opcode_e opcode_of(input logic [INSTR_W-1:0] word);
    return opcode_e'(word[8:6]);
  endfunction

endpackage

// File: rtl/feeder_wdog.sv
// Loadable down-counter used as the per-instruction watchdog.
// Ports: clk_i/rst_i (sync, active-high), load_i + load_val_i reload the
// count, dec_i decrements it (saturating at zero), expired_o is high while
// the count is zero.
module feeder_wdog
  import instr_feeder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WDOG_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              expired_o
);

  logic [WDOG_W-1:0] cnt_q;

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WDOG_W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: walks a synchronous program ROM and hands each
// instruction (plus the immediate word for mvi) to a multi-cycle processor,
// gating the processor with ProcEn and waiting for its Done strobe.
// Ports: Clock, Resetn (sync, active-high), Run enable; mem_addr/mem_data
// to the 1-cycle-latency ROM; DIN/ProcEn/Done to the processor; PC,
// Halted, Fault and InstrCount as status.
// DIN and ProcEn are same-cycle decodes because the ROM word only becomes
// valid in the ISSUE cycle that must already present it.
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [15:0] HALT_WORD = HALT_WORD_DEF,
  parameter int unsigned WDOG      = 4   // must be >= 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data,
  output logic [15:0]       DIN,
  output logic              ProcEn,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Halted,
  output logic              Fault,
  output logic [15:0]       InstrCount
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       icount_q, icount_d;
  logic [15:0]       ir_q, ir_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [15:0]       din_c;
  logic              proc_en_c;
  logic              wd_load_c, wd_dec_c, wd_expired;

  // ISSUE already spends one enabled cycle, so EXEC gets WDOG-1 cycles:
  // the counter reads zero on the last permitted EXEC cycle.
  feeder_wdog u_wdog (
    .clk_i      (Clock),
    .rst_i      (Resetn),
    .load_i     (wd_load_c),
    .load_val_i (WDOG_W'(WDOG - 2)),
    .dec_i      (wd_dec_c),
    .expired_o  (wd_expired)
  );

  // Next-state and processor-interface decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    icount_d  = icount_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    din_c     = '0;
    proc_en_c = 1'b0;
    wd_load_c = 1'b0;
    wd_dec_c  = 1'b0;

    unique case (state_q)
      IDLE: if (Run) state_d = FETCH;
      FETCH: state_d = ISSUE;
      ISSUE: begin
        ir_d = mem_data;
        if (mem_data == HALT_WORD) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else begin
          din_c     = mem_data;
          proc_en_c = 1'b1;
          wd_load_c = 1'b1;
          if (opcode_of(mem_data) == OP_MVI) begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = FETCH_IMM;
          end else begin
            state_d = EXEC;
          end
        end
      end
      FETCH_IMM: state_d = ISSUE_IMM;
      ISSUE_IMM: begin
        din_c     = mem_data;
        proc_en_c = 1'b1;
        if (Done) begin
          pc_d     = pc_q + ADDR_W'(1);
          icount_d = icount_q + 16'd1;
          state_d  = Run ? FETCH : IDLE;
        end else begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      EXEC: begin
        din_c     = ir_q;
        proc_en_c = 1'b1;
        wd_dec_c  = 1'b1;
        if (Done) begin
          pc_d     = pc_q + ADDR_W'(1);
          icount_d = icount_q + 16'd1;
          state_d  = Run ? FETCH : IDLE;
        end else if (wd_expired) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset overrides any same-cycle Done.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      icount_q <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign mem_addr   = pc_q;
  assign PC         = pc_q;
  assign InstrCount = icount_q;
  assign Halted     = halted_q;
  assign Fault      = fault_q;
  assign DIN        = din_c;
  assign ProcEn     = proc_en_c;

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: every expected enabled cycle
// (DIN, PC) is queued by the stimulus; a negedge monitor pops and compares
// whenever ProcEn is high. Status outputs are checked directly.
module tb_instr_feeder;

  localparam int unsigned AW = 6;

  typedef struct packed {
    logic [15:0]   din;
    logic [AW-1:0] pc;
  } exp_t;

  logic          Clock = 1'b0;
  logic          Resetn, Run, Done;
  logic [AW-1:0] mem_addr, PC;
  logic [15:0]   mem_data, DIN, InstrCount;
  logic          ProcEn, Halted, Fault;

  logic [15:0] rom [64];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  instr_feeder #(.ADDR_W(AW), .HALT_WORD(16'hFFFF), .WDOG(4)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Run        (Run),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .DIN        (DIN),
    .ProcEn     (ProcEn),
    .Done       (Done),
    .PC         (PC),
    .Halted     (Halted),
    .Fault      (Fault),
    .InstrCount (InstrCount)
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM, one cycle read latency.
  always @(posedge Clock) mem_data <= rom[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: each enabled cycle must match the next queued expectation.
  always @(negedge Clock) begin
    if (ProcEn === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: ProcEn=1 DIN=%h PC=%0d want ProcEn=0", DIN, PC);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_din", 32'(DIN), 32'(e.din));
        chk("sb_pc", 32'(PC), 32'(e.pc));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_en(input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (ProcEn !== 1'b1 && n < 20);
    total++;
    if (ProcEn !== 1'b1) begin
      bad++;
      $display("FAIL %s: ProcEn=%b want 1 within 20 cycles", nm, ProcEn);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [AW-1:0] p);
    exp_t e;
    e.din = d;
    e.pc  = p;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    Resetn = 1'b1;
    Run    = 1'b0;
    Done   = 1'b0;
    tick();
    tick();
    Resetn = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'h0008;
    Resetn = 1'b1; Run = 1'b0; Done = 1'b0;
    tick(); tick();
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_icount", 32'(InstrCount), 32'd0);
    chk("rst_procen", 32'(ProcEn), 32'd0);
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    Resetn = 1'b0;
    tick();
    chk("idle_procen", 32'(ProcEn), 32'd0);

    // mv R1,R0 completes in EXEC; Run dropped with Done -> IDLE
    rom[0] = 16'h0008;
    push(16'h0008, 6'd0); push(16'h0008, 6'd0);
    Run = 1'b1;
    wait_en("t1_issue");
    wait_en("t1_exec");
    Done = 1'b1; Run = 1'b0;
    tick();
    Done = 1'b0;
    chk("t1_pc", 32'(PC), 32'd1);
    chk("t1_icount", 32'(InstrCount), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'd1);
    tick();
    chk("t1_idle_procen", 32'(ProcEn), 32'd0);
    chk("t1_idle_din", 32'(DIN), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // mvi R0,#0x1234 then halt word at address 2
    do_reset();
    rom[0] = 16'h0040; rom[1] = 16'h1234; rom[2] = 16'hFFFF;
    push(16'h0040, 6'd0); push(16'h1234, 6'd1);
    Run = 1'b1;
    wait_en("t2_issue");
    wait_en("t2_imm");
    chk("t2_imm_addr", 32'(mem_addr), 32'd1);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("t2_pc", 32'(PC), 32'd2);
    chk("t2_icount", 32'(InstrCount), 32'd1);
    tick();
    chk("t2_halt_issue_procen", 32'(ProcEn), 32'd0);
    chk("t2_halt_issue_halted", 32'(Halted), 32'd0);
    tick();
    chk("t2_halted", 32'(Halted), 32'd1);
    chk("t2_halt_pc", 32'(PC), 32'd2);
    chk("t2_halt_din", 32'(DIN), 32'd0);
    tick(); tick(); tick();
    chk("t2_halt_sticky", 32'(Halted), 32'd1);
    chk("t2_halt_pc_hold", 32'(PC), 32'd2);

    // add with Done withheld -> watchdog fault after 4 enabled cycles
    do_reset();
    rom[0] = 16'h0080;
    for (int i = 0; i < 4; i++) push(16'h0080, 6'd0);
    Run = 1'b1;
    wait_en("t3_issue");
    tick(); tick(); tick();
    chk("t3_last_en", 32'(ProcEn), 32'd1);
    chk("t3_no_fault_yet", 32'(Fault), 32'd0);
    tick();
    chk("t3_fault", 32'(Fault), 32'd1);
    chk("t3_fault_procen", 32'(ProcEn), 32'd0);
    chk("t3_fault_din", 32'(DIN), 32'd0);
    Done = 1'b1;
    tick(); tick();
    Done = 1'b0;
    chk("t3_done_ignored", 32'(InstrCount), 32'd0);
    chk("t3_fault_sticky", 32'(Fault), 32'd1);
    do_reset();
    chk("t3_fault_cleared", 32'(Fault), 32'd0);

    // run through addresses 0..62, then mvi at 63 wraps to address 0
    rom[0] = 16'h0038;
    for (int i = 1; i < 63; i++) rom[i] = 16'h0008;
    rom[63] = 16'h0040;
    Run = 1'b1;
    for (int i = 0; i < 63; i++) begin
      push(rom[i], AW'(i)); push(rom[i], AW'(i));
      wait_en("t4_issue");
      wait_en("t4_exec");
      Done = 1'b1;
      tick();
      Done = 1'b0;
    end
    chk("t4_pc63", 32'(PC), 32'd63);
    push(16'h0040, 6'd63); push(16'h0038, 6'd0);
    wait_en("t4_mvi_issue");
    wait_en("t4_mvi_imm");
    chk("t4_wrap_addr", 32'(mem_addr), 32'd0);
    Done = 1'b1; Run = 1'b0;
    tick();
    Done = 1'b0;
    chk("t4_pc", 32'(PC), 32'd1);
    chk("t4_icount", 32'(InstrCount), 32'd64);
    tick();
    chk("t4_idle_procen", 32'(ProcEn), 32'd0);

    // reset in EXEC with Done in the same cycle
    do_reset();
    rom[0] = 16'h0008;
    push(16'h0008, 6'd0); push(16'h0008, 6'd0);
    Run = 1'b1;
    wait_en("t5_issue");
    wait_en("t5_exec");
    Done = 1'b1; Resetn = 1'b1; Run = 1'b0;
    tick();
    Done = 1'b0; Resetn = 1'b0;
    chk("t5_pc", 32'(PC), 32'd0);
    chk("t5_icount", 32'(InstrCount), 32'd0);
    chk("t5_procen", 32'(ProcEn), 32'd0);
    tick(); tick();
    chk("t5_idle_procen", 32'(ProcEn), 32'd0);
    chk("t5_idle_pc", 32'(PC), 32'd0);

    // Run dropped mid-EXEC: sub still completes, then IDLE
    do_reset();
    rom[0] = 16'h00C0;
    for (int i = 0; i < 3; i++) push(16'h00C0, 6'd0);
    Run = 1'b1;
    wait_en("t6_issue");
    wait_en("t6_exec");
    Run = 1'b0;
    tick();
    chk("t6_hold_procen", 32'(ProcEn), 32'd1);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("t6_pc", 32'(PC), 32'd1);
    chk("t6_icount", 32'(InstrCount), 32'd1);
    tick(); tick();
    chk("t6_idle_procen", 32'(ProcEn), 32'd0);
    chk("t6_idle_pc", 32'(PC), 32'd1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 6, width of the program-memory address; HALT_WORD, default 16'hFFFF, instruction word that stops fetching; WDOG, default 4, maximum enabled cycles from instruction issue to Done.
REQ-002 Clock  in  1  single clock; every register updates on the rising edge.
REQ-003 Resetn  in  1  reset; it is synchronous and active-high.
REQ-004 Run  in  1  run enable; the block fetches only while Run is high.
REQ-005 mem_addr  out  ADDR_W  address to the synchronous program ROM; read latency is 1 cycle.
REQ-006 mem_data  in  16  ROM read data; it is valid one cycle after mem_addr.
REQ-007 DIN  out  16  instruction or immediate word presented to the processor.
REQ-008 ProcEn  out  1  processor clock-enable; the processor step counter advances only when ProcEn is high.
REQ-009 Done  in  1  processor instruction-complete strobe; it is sampled only when ProcEn is high.
REQ-010 PC  out  ADDR_W  address of the current instruction.
REQ-011 Halted  out  1  high once HALT_WORD has been fetched.
REQ-012 Fault  out  1  sticky watchdog-expiry flag.
REQ-013 InstrCount  out  16  count of completed instructions.

Function
REQ-014 The states SHALL be IDLE, FETCH, ISSUE, FETCH_IMM, ISSUE_IMM, EXEC, HALT and FAULT.
REQ-015 IDLE: ProcEn=0; go to FETCH when Run=1.
REQ-016 FETCH: drive mem_addr=PC with ProcEn=0; go to ISSUE on the next cycle.
REQ-017 ISSUE: latch mem_data into the instruction register and drive DIN=mem_data, ProcEn=1 for exactly one cycle (processor step 0).
REQ-018 ISSUE, HALT_WORD fetched: go to HALT instead; ProcEn SHALL stay 0 in that cycle.
REQ-019 ISSUE, opcode field mem_data[8:6]=3'b001 (mvi): PC SHALL increment and the FSM goes to FETCH_IMM.
REQ-020 ISSUE, any other opcode: go to EXEC.
REQ-021 FETCH_IMM: drive mem_addr=PC with ProcEn=0; go to ISSUE_IMM.
REQ-022 ISSUE_IMM: drive DIN=mem_data and ProcEn=1 for one cycle (processor step 1).
REQ-023 ISSUE_IMM, Done=1 sampled: complete the instruction (REQ-025).
REQ-024 ISSUE_IMM, Done=0: go to FAULT.
REQ-025 EXEC: hold DIN at the instruction word with ProcEn=1; when Done=1 is sampled the instruction completes: PC increments, InstrCount increments, and the FSM goes to FETCH (or IDLE if Run=0).
REQ-026 Run falling mid-instruction SHALL NOT abort the instruction; the current instruction completes before IDLE is entered.
REQ-027 Watchdog: count enabled cycles from ISSUE; if the count reaches WDOG without Done, go to FAULT.
REQ-028 Entering FAULT SHALL set Fault=1 and ProcEn=0.
REQ-029 FAULT and HALT SHALL be exited only by reset.
REQ-030 PC SHALL wrap modulo 2^ADDR_W (63 -> 0); an mvi whose opcode sits at the last address fetches its immediate from address 0.
REQ-031 InstrCount SHALL wrap 16'hFFFF -> 0.
REQ-032 Done seen while ProcEn=0 SHALL be ignored.
REQ-033 DIN SHALL be 0 in IDLE, FETCH, FETCH_IMM, HALT and FAULT.
REQ-034 Halted SHALL be 1 only in HALT.
REQ-035 mem_addr SHALL equal PC at all times.

Reset
REQ-036 Resetn=1 at a clock edge SHALL force: state IDLE, PC=0, InstrCount=0, DIN=0, ProcEn=0, Halted=0, Fault=0, watchdog=0, instruction register=0.
REQ-037 Reset SHALL take priority over every other event, including a Done arriving in the same cycle; the processor is reset on the same Resetn.

Structure
REQ-038 A shared package SHALL hold the state encoding, the opcode constants (mv=000 through slr=111) and the HALT_WORD default, used jointly with the processor.
REQ-039 One sub-module SHALL exist: feeder_wdog, a loadable down-counter with an expiry flag.
REQ-040 There SHALL be no other hierarchy; the ROM stays outside the block.

Verification
REQ-041 ROM[0]=mv R1,R0 (0x0008), Run=1, Done pulsed in EXEC -> ProcEn high 2 cycles, DIN=0x0008, PC 0->1, InstrCount=1.
REQ-042 ROM[0]=0x0040 (mvi R0), ROM[1]=0x1234 -> DIN 0x0040 then 0x1234 on consecutive enabled cycles, Done at the second -> PC=2.
REQ-043 ROM[2]=0xFFFF -> Halted=1 at cycle ISSUE+1, ProcEn stays 0, PC stays 2.
REQ-044 add instruction with Done withheld -> Fault=1 after 4 enabled cycles, ProcEn=0 until reset.
REQ-045 mvi at address 63 -> immediate read from address 0, PC=1 afterwards.
REQ-046 Resetn asserted in EXEC with Done=1 in the same cycle -> PC=0, InstrCount=0, state IDLE; Run dropped mid-EXEC -> instruction completes, then IDLE.
